alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock; the single clock of the block.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  operation enable; result and flags update only when high.
REQ-005 oe  input  1  output enable; ALU_OUT is driven when high and high-Z when low.
REQ-006 OPCODE  input  4  operation select.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 ALU_OUT  output  WIDTH  registered result, tri-stated by oe.
REQ-010 CF  output  1  carry/borrow flag.
REQ-011 OF  output  1  two's-complement overflow flag.
REQ-012 SF  output  1  sign flag, equal to result MSB.
REQ-013 ZF  output  1  zero flag, high when the result is all zeros.

Function
REQ-014 Opcodes SHALL be decoded as follows:
- 0000 pass A
- 0001 pass B
- 0010 A+B
- 0011 A-B
- 0100 A AND B
- 0101 A OR B
- 0110 A XOR B
- 0111 NOT A (B ignored)
- 1000 A shifted left 1 (logical)
- 1001 A shifted right 1 (logical)
- 1010 A shifted right 1 (arithmetic)
- 1011-1111 result 0.
REQ-015 On a rising clk edge with rst low and en high, the result register and all four flags SHALL load the combinational values, giving 1-cycle latency.
REQ-016 With en low, the result register and flags SHALL hold their values.
REQ-017 ALU_OUT SHALL equal the result register when oe=1 and all-Z when oe=0, combinationally from oe, with no effect on register contents.
REQ-018 Flags SHALL stay driven regardless of oe.
REQ-019 ADD: CF = carry out of bit WIDTH-1; OF = 1 when both operands have equal sign and the result sign differs; result wraps modulo 2^WIDTH.
REQ-020 SUB: computed as A + ~B + 1; CF = borrow (1 when A < B unsigned); OF = 1 when the operand signs differ and the result sign differs from A; result wraps modulo 2^WIDTH.
REQ-021 Logic, pass and default ops: CF=0, OF=0.
REQ-022 Shift ops: CF = the bit shifted out; OF=0.
REQ-023 SF SHALL be result[WIDTH-1] and ZF SHALL be (result==0) for every opcode, including default.
REQ-024 Operands SHALL be treated as raw bit vectors; the unsigned and signed interpretations yield identical result bits, and only the flag meaning differs.

Reset
REQ-025 On a rising clk with rst high, the result register SHALL be set to 0 and CF, OF and SF to 0; ZF SHALL be set to 1, consistent with a zero result.
REQ-026 rst SHALL take priority over en.
REQ-027 ALU_OUT during and after reset SHALL follow REQ-017.

Structure
REQ-028 Package alu_pkg SHALL hold the opcode enum (4-bit) and the default WIDTH constant.
REQ-029 One sub-module, alu_addsub, SHALL compute WIDTH-bit add/subtract with carry-out and overflow.
REQ-030 Logic, shifts, flag generation, registers and the tri-state driver SHALL reside in alu.

Verification
REQ-031 rst=1 for one clk -> ALU_OUT=00, CF=0, OF=0, SF=0, ZF=1.
REQ-032 en=1, oe=1, OPCODE=0010, A=7F, B=01 -> next edge ALU_OUT=80, CF=0, OF=1, SF=1, ZF=0; A=FF, B=01 -> 00, CF=1, OF=0, ZF=1.
REQ-033 OPCODE=0011 (SUB):
- A=DA, B=64 -> 76, CF=0, OF=1, SF=0
- A=5A, B=D9 -> 81, CF=1, OF=1, SF=1
REQ-034 Logic ops:
- AND AA,CC -> 88, SF=1
- OR F0,3C -> FC
- XOR 55,55 -> 00, ZF=1
- NOT AA -> 55
- NOT DB -> 24
REQ-035 oe=0, en=1 -> ALU_OUT=ZZ while flags remain driven; returning oe to 1 restores the last result without a clock edge.
REQ-036 en=0 with new A/B/OPCODE for 3 cycles -> ALU_OUT and flags unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode encoding and default width for the alu
// Contents:
//   ALU_WIDTH : default operand/result width
//   opcode_e  : 4-bit operation select; codes 1011-1111 are unassigned and give zero
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [3:0] {
    OP_PASS_A = 4'b0000,
    OP_PASS_B = 4'b0001,
    OP_ADD    = 4'b0010,
    OP_SUB    = 4'b0011,
    OP_AND    = 4'b0100,
    OP_OR     = 4'b0101,
    OP_XOR    = 4'b0110,
    OP_NOT    = 4'b0111,
    OP_SHL    = 4'b1000,
    OP_SHR    = 4'b1001,
    OP_SAR    = 4'b1010
  } opcode_e;

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - WIDTH-bit adder/subtractor with carry-out and overflow
// Ports:
//   a, b      : operands (raw bit vectors)
//   sub       : 0 -> a + b, 1 -> a + ~b + 1
//   sum       : wrapped WIDTH-bit result
//   carry_out : carry out of bit WIDTH-1 of the internal addition (not yet a borrow)
//   overflow  : two's-complement overflow of the selected operation
module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;

  assign b_eff   = sub ? ~b : b;
  assign sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

  assign sum       = sum_ext[WIDTH-1:0];
  assign carry_out = sum_ext[WIDTH];
  // Overflow when the addends agree in sign but the sum does not; using the
  // inverted B covers the subtract case with the same expression.
  assign overflow  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered ALU with status flags and tri-stated result output
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   en           : result/flag registers load only when high
//   oe           : ALU_OUT drives the result register when high, high-Z when low
//   OPCODE, A, B : operation select and operands
//   ALU_OUT      : registered result (tri-stated)
//   CF, OF, SF, ZF : registered carry/borrow, overflow, sign and zero flags
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             oe,
  input  logic [3:0]       OPCODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             CF,
  output logic             OF,
  output logic             SF,
  output logic             ZF
);

  logic [WIDTH-1:0] as_sum;
  logic             as_carry;
  logic             as_ovf;
  logic             is_sub;

  logic [WIDTH-1:0] res_d;
  logic             cf_d;
  logic             of_d;

  logic [WIDTH-1:0] result_q;

  assign is_sub = (OPCODE == OP_SUB);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a         (A),
    .b         (B),
    .sub       (is_sub),
    .sum       (as_sum),
    .carry_out (as_carry),
    .overflow  (as_ovf)
  );

  always_comb begin
    res_d = '0;
    cf_d  = 1'b0;
    of_d  = 1'b0;
    case (opcode_e'(OPCODE))
      OP_PASS_A: res_d = A;
      OP_PASS_B: res_d = B;
      OP_ADD: begin
        res_d = as_sum;
        cf_d  = as_carry;
        of_d  = as_ovf;
      end
      OP_SUB: begin
        res_d = as_sum;
        // A + ~B + 1 carries out exactly when no borrow occurred.
        cf_d  = ~as_carry;
        of_d  = as_ovf;
      end
      OP_AND: res_d = A & B;
      OP_OR:  res_d = A | B;
      OP_XOR: res_d = A ^ B;
      OP_NOT: res_d = ~A;
      OP_SHL: begin
        res_d = {A[WIDTH-2:0], 1'b0};
        cf_d  = A[WIDTH-1];
      end
      OP_SHR: begin
        res_d = {1'b0, A[WIDTH-1:1]};
        cf_d  = A[0];
      end
      OP_SAR: begin
        res_d = {A[WIDTH-1], A[WIDTH-1:1]};
        cf_d  = A[0];
      end
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      CF       <= 1'b0;
      OF       <= 1'b0;
      SF       <= 1'b0;
      ZF       <= 1'b1;
    end else if (en) begin
      result_q <= res_d;
      CF       <= cf_d;
      OF       <= of_d;
      SF       <= res_d[WIDTH-1];
      ZF       <= (res_d == '0);
    end
  end

  assign ALU_OUT = oe ? result_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu against an arithmetic reference model
module tb_alu;

  logic       clk;
  logic       rst;
  logic       en;
  logic       oe;
  logic [3:0] opcode;
  logic [7:0] a;
  logic [7:0] b;
  tri1  [7:0] alu_out_bus;
  logic       cf;
  logic       of;
  logic       sf;
  logic       zf;

  int checks;
  int failures;

  // Registered state as the bench believes it to be: {result, CF, OF, SF, ZF}.
  logic [11:0] exp_state;

  alu #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .oe      (oe),
    .OPCODE  (opcode),
    .A       (a),
    .B       (b),
    .ALU_OUT (alu_out_bus),
    .CF      (cf),
    .OF      (of),
    .SF      (sf),
    .ZF      (zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed readings of the operands.
  function automatic logic [11:0] model_alu(input logic [3:0] op, input logic [7:0] av,
                                            input logic [7:0] bv);
    int ua = int'(av);
    int ub = int'(bv);
    int sa = int'($signed(av));
    int sb = int'($signed(bv));
    int r = 0;
    int sr = 0;
    logic c = 1'b0;
    logic o = 1'b0;
    logic [7:0] res;
    case (op)
      4'd0: r = ua;
      4'd1: r = ub;
      4'd2: begin r = ua + ub; c = (r > 255); sr = sa + sb; o = (sr > 127) || (sr < -128); end
      4'd3: begin r = ua - ub; c = (ua < ub); sr = sa - sb; o = (sr > 127) || (sr < -128); end
      4'd4: r = int'(av & bv);
      4'd5: r = int'(av | bv);
      4'd6: r = int'(av ^ bv);
      4'd7: r = 255 - ua;
      4'd8: begin r = ua * 2; c = (ua >= 128); end
      4'd9: begin r = ua / 2; c = (ua % 2) == 1; end
      4'd10: begin r = ua / 2 + ((ua >= 128) ? 128 : 0); c = (ua % 2) == 1; end
      default: r = 0;
    endcase
    res = r[7:0];
    return {res, c, o, (res >= 8'd128), (res == 8'd0)};
  endfunction

  task automatic step(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                      input logic en_i);
    @(negedge clk);
    opcode = op;
    a      = av;
    b      = bv;
    en     = en_i;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; en = 1'b0; oe = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_state = {8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if ({alu_out_bus, cf, of, sf, zf} !== exp_state) begin
      failures++;
      $display("FAIL reset: got %h expected %h", {alu_out_bus, cf, of, sf, zf}, exp_state);
    end
  endtask

  task automatic test_directed;
    logic [3:0]  ops  [11] = '{4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7, 4'd8, 4'd10};
    logic [7:0]  as   [11] = '{8'h7F, 8'hFF, 8'hDA, 8'h5A, 8'hAA, 8'hF0, 8'h55, 8'hAA, 8'hDB, 8'h81, 8'h81};
    logic [7:0]  bs   [11] = '{8'h01, 8'h01, 8'h64, 8'hD9, 8'hCC, 8'h3C, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [11:0] want [11] = '{{8'h80, 4'b0110}, {8'h00, 4'b1001}, {8'h76, 4'b0100},
                               {8'h81, 4'b1110}, {8'h88, 4'b0010}, {8'hFC, 4'b0010},
                               {8'h00, 4'b0001}, {8'h55, 4'b0000}, {8'h24, 4'b0000},
                               {8'h02, 4'b1000}, {8'hC0, 4'b1010}};
    oe = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step(ops[i], as[i], bs[i], 1'b1);
      exp_state = want[i];
      checks++;
      if ({alu_out_bus, cf, of, sf, zf} !== want[i]) begin
        failures++;
        $display("FAIL directed[%0d] op=%h a=%h b=%h: got %h expected %h",
                 i, ops[i], as[i], bs[i], {alu_out_bus, cf, of, sf, zf}, want[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] op;
    logic [7:0] av, bv;
    logic       en_i;
    oe = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op   = 4'($urandom_range(0, 15));
      av   = 8'($urandom);
      bv   = 8'($urandom);
      en_i = ($urandom_range(0, 3) != 0);
      step(op, av, bv, en_i);
      if (en_i) exp_state = model_alu(op, av, bv);
      checks++;
      if ({alu_out_bus, cf, of, sf, zf} !== exp_state) begin
        failures++;
        $display("FAIL random[%0d] op=%h a=%h b=%h en=%b: got %h expected %h",
                 i, op, av, bv, en_i, {alu_out_bus, cf, of, sf, zf}, exp_state);
      end
    end
  endtask

  task automatic test_oe;
    oe = 1'b1;
    step(4'd0, 8'h55, 8'h00, 1'b1);
    exp_state = model_alu(4'd0, 8'h55, 8'h00);
    @(negedge clk);
    oe = 1'b0;
    #1;
    checks++;
    if ({alu_out_bus, cf, of, sf, zf} !== {8'hFF, exp_state[3:0]}) begin
      failures++;
      $display("FAIL oe_release: got %h expected %h", {alu_out_bus, cf, of, sf, zf},
               {8'hFF, exp_state[3:0]});
    end
    step(4'd1, 8'h00, 8'hB3, 1'b1);
    exp_state = model_alu(4'd1, 8'h00, 8'hB3);
    checks++;
    if ({alu_out_bus, cf, of, sf, zf} !== {8'hFF, exp_state[3:0]}) begin
      failures++;
      $display("FAIL oe_flags_driven: got %h expected %h", {alu_out_bus, cf, of, sf, zf},
               {8'hFF, exp_state[3:0]});
    end
    @(negedge clk);
    en = 1'b0;
    #2;
    oe = 1'b1;
    #1;
    checks++;
    if ({alu_out_bus, cf, of, sf, zf} !== exp_state) begin
      failures++;
      $display("FAIL oe_restore: got %h expected %h", {alu_out_bus, cf, of, sf, zf}, exp_state);
    end
  endtask

  task automatic test_hold;
    oe = 1'b1;
    step(4'd3, 8'h10, 8'h20, 1'b1);
    exp_state = model_alu(4'd3, 8'h10, 8'h20);
    for (int i = 0; i < 3; i++) begin
      step(4'($urandom_range(0, 10)), 8'($urandom), 8'($urandom), 1'b0);
      checks++;
      if ({alu_out_bus, cf, of, sf, zf} !== exp_state) begin
        failures++;
        $display("FAIL hold[%0d]: got %h expected %h", i, {alu_out_bus, cf, of, sf, zf}, exp_state);
      end
    end
  endtask

  task automatic test_reset_priority;
    oe = 1'b1;
    step(4'd0, 8'hA5, 8'h00, 1'b1);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; opcode = 4'd2; a = 8'h80; b = 8'h80; oe = 1'b0;
    @(posedge clk); #1;
    exp_state = {8'h00, 4'b0001};
    checks++;
    if ({alu_out_bus, cf, of, sf, zf} !== {8'hFF, exp_state[3:0]}) begin
      failures++;
      $display("FAIL reset_priority_oe0: got %h expected %h", {alu_out_bus, cf, of, sf, zf},
               {8'hFF, exp_state[3:0]});
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b0; oe = 1'b1;
    #1;
    checks++;
    if ({alu_out_bus, cf, of, sf, zf} !== exp_state) begin
      failures++;
      $display("FAIL reset_priority: got %h expected %h", {alu_out_bus, cf, of, sf, zf}, exp_state);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b0; oe = 1'b1; opcode = 4'd0; a = 8'h00; b = 8'h00;
    exp_state = '0;
    test_reset();
    test_directed();
    test_random();
    test_oe();
    test_hold();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
